// File: rtl/asteroid_hit_detector.sv
// Scans the asteroid table once per frame tick for a bullet overlap.
// Optional SHIP_COLLISION_EN adds a ship box test and ship_hit output.
module asteroid_hit_detector #(
  parameter int ASTEROID_COUNT = 4,
  parameter int ENTITY_SIZE    = 34,
  parameter int ADDR_W         = 2,
  parameter int ASTEROID_W     = 16,
  parameter int POINTS         = 10
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [ASTEROID_COUNT*ENTITY_SIZE-1:0] asteroids_data,
  input  logic                                 bullet_valid,
  input  logic [9:0]                           bullet_x,
  input  logic [9:0]                           bullet_y,
`ifdef SHIP_COLLISION_EN
  input  logic [9:0]                           ship_x,
  input  logic [9:0]                           ship_y,
  output logic                                 ship_hit,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 delete_asteroid,
  output logic [ADDR_W-1:0]                    asteroid_address,
  output logic                                 bullet_consume,
  output logic [15:0]                          score
);

  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

  localparam int AST_BITS = ASTEROID_COUNT * ENTITY_SIZE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ASTEROID_COUNT - 1);

  state_t                state_q, state_d;
  logic [AST_BITS-1:0]   ast_q, ast_d;
  logic                  bv_q, bv_d;
  logic [9:0]            bx_q, bx_d;
  logic [9:0]            by_q, by_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]     hit_idx_q, hit_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  del_q, del_d;
  logic                  cons_q, cons_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [15:0]           score_q, score_d;

  logic [ENTITY_SIZE-1:0] ent_arr [ASTEROID_COUNT];
  logic [ENTITY_SIZE-1:0] ent;
  logic [10:0]            ex, ey;
  logic                   bullet_hit;
  logic [16:0]            score_sum;
  logic [15:0]            score_sat;
  logic                   unused_bits;

`ifdef SHIP_COLLISION_EN
  localparam int SHIP_W = 16;
  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
  logic       found_q, found_d;
  logic       ship_any_q, ship_any_d;
  logic       ship_hit_q, ship_hit_d;
  logic       ship_ov;
`endif

  // Unpack the snapshot into per-entry slots and select the current one
  always_comb begin
    for (int i = 0; i < ASTEROID_COUNT; i++) begin
      ent_arr[i] = ast_q[i*ENTITY_SIZE +: ENTITY_SIZE];
    end
    ent = ent_arr[idx_q];
  end

  assign ex = {1'b0, ent[15:6]};
  assign ey = {1'b0, ent[25:16]};
  assign unused_bits = ^{ent[32:26], ent[5:0]};

  assign bullet_hit = ent[33] && bv_q
    && ({1'b0, bx_q} >= ex)
    && ({1'b0, bx_q} <= ex + 11'(ASTEROID_W - 1))
    && ({1'b0, by_q} >= ey)
    && ({1'b0, by_q} <= ey + 11'(ASTEROID_W - 1));

`ifdef SHIP_COLLISION_EN
  assign ship_ov = ent[33]
    && (ex <= {1'b0, sx_q} + 11'(SHIP_W - 1))
    && ({1'b0, sx_q} <= ex + 11'(ASTEROID_W - 1))
    && (ey <= {1'b0, sy_q} + 11'(SHIP_W - 1))
    && ({1'b0, sy_q} <= ey + 11'(ASTEROID_W - 1));
`endif

  assign score_sum = {1'b0, score_q} + 17'(POINTS);
  assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    ast_d     = ast_q;
    bv_d      = bv_q;
    bx_d      = bx_q;
    by_d      = by_q;
    idx_d     = idx_q;
    hit_idx_d = hit_idx_q;
    done_d    = 1'b0;
    del_d     = 1'b0;
    cons_d    = 1'b0;
    addr_d    = addr_q;
    score_d   = score_q;
`ifdef SHIP_COLLISION_EN
    sx_d       = sx_q;
    sy_d       = sy_q;
    found_d    = found_q;
    ship_any_d = ship_any_q;
    ship_hit_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ast_d   = asteroids_data;
          bv_d    = bullet_valid;
          bx_d    = bullet_x;
          by_d    = bullet_y;
          idx_d   = '0;
          state_d = SCAN;
`ifdef SHIP_COLLISION_EN
          sx_d       = ship_x;
          sy_d       = ship_y;
          found_d    = 1'b0;
          ship_any_d = 1'b0;
`endif
        end
      end
      SCAN: begin
`ifdef SHIP_COLLISION_EN
        if (bullet_hit && !found_q) begin
          found_d   = 1'b1;
          hit_idx_d = idx_q;
        end
        ship_any_d = ship_any_q | ship_ov;
        if (idx_q == LAST) begin
          if (found_d) begin
            state_d = HIT;
            del_d   = 1'b1;
            cons_d  = 1'b1;
            addr_d  = hit_idx_d;
            score_d = score_sat;
          end else begin
            state_d    = DONE;
            done_d     = 1'b1;
            ship_hit_d = ship_any_d;
          end
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
`else
        if (bullet_hit) begin
          hit_idx_d = idx_q;
          state_d   = HIT;
          del_d     = 1'b1;
          cons_d    = 1'b1;
          addr_d    = idx_q;
          score_d   = score_sat;
        end else if (idx_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
`endif
      end
      HIT: begin
        state_d = DONE;
        done_d  = 1'b1;
`ifdef SHIP_COLLISION_EN
        ship_hit_d = ship_any_q;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ast_q     <= '0;
      bv_q      <= 1'b0;
      bx_q      <= '0;
      by_q      <= '0;
      idx_q     <= '0;
      hit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      del_q     <= 1'b0;
      cons_q    <= 1'b0;
      addr_q    <= '0;
      score_q   <= '0;
`ifdef SHIP_COLLISION_EN
      sx_q       <= '0;
      sy_q       <= '0;
      found_q    <= 1'b0;
      ship_any_q <= 1'b0;
      ship_hit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ast_q     <= ast_d;
      bv_q      <= bv_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      idx_q     <= idx_d;
      hit_idx_q <= hit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      del_q     <= del_d;
      cons_q    <= cons_d;
      addr_q    <= addr_d;
      score_q   <= score_d;
`ifdef SHIP_COLLISION_EN
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      found_q    <= found_d;
      ship_any_q <= ship_any_d;
      ship_hit_q <= ship_hit_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign delete_asteroid  = del_q;
  assign bullet_consume   = cons_q;
  assign asteroid_address = addr_q;
  assign score            = score_q;
`ifdef SHIP_COLLISION_EN
  assign ship_hit = ship_hit_q;
`endif

endmodule

// File: tb/tb_asteroid_hit_detector.sv
// Self-checking bench for asteroid_hit_detector.
// Directed and random scans checked against a geometric reference model.
module tb_asteroid_hit_detector;
  localparam int N  = 4;
  localparam int ES = 34;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [N*ES-1:0]   asteroids_data;
  logic              bullet_valid;
  logic [9:0]        bullet_x, bullet_y;
  logic              busy, done, delete_asteroid, bullet_consume;
  logic [AW-1:0]     asteroid_address;
  logic [15:0]       score;
`ifdef SHIP_COLLISION_EN
  logic [9:0]        ship_x, ship_y;
  logic              ship_hit;
`endif

  int checks = 0;
  int failures = 0;
  int exp_score = 0;

  always #5 clk = ~clk;

  asteroid_hit_detector dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .asteroids_data(asteroids_data),
    .bullet_valid(bullet_valid),
    .bullet_x(bullet_x),
    .bullet_y(bullet_y),
`ifdef SHIP_COLLISION_EN
    .ship_x(ship_x),
    .ship_y(ship_y),
    .ship_hit(ship_hit),
`endif
    .busy(busy),
    .done(done),
    .delete_asteroid(delete_asteroid),
    .asteroid_address(asteroid_address),
    .bullet_consume(bullet_consume),
    .score(score)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ES-1:0] ent(input bit v, input int x, input int y);
    logic [ES-1:0] e;
    e = '0;
    e[33] = v;
    e[25:16] = y[9:0];
    e[15:6] = x[9:0];
    return e;
  endfunction

  // Lowest entry whose 16x16 box contains the bullet, or -1.
  function automatic int model_hit(input logic [N*ES-1:0] d, input bit bv,
                                   input int bx, input int by);
    logic [ES-1:0] e;
    int x, y;
    for (int i = 0; i < N; i++) begin
      e = d[i*ES +: ES];
      x = int'(e[15:6]);
      y = int'(e[25:16]);
      if (e[33] && bv && bx >= x && bx <= x + 15 && by >= y && by <= y + 15)
        return i;
    end
    return -1;
  endfunction

  function automatic int model_ship(input logic [N*ES-1:0] d, input int sx, input int sy);
    logic [ES-1:0] e;
    int x, y;
    for (int i = 0; i < N; i++) begin
      e = d[i*ES +: ES];
      x = int'(e[15:6]);
      y = int'(e[25:16]);
      if (e[33] && x <= sx + 15 && sx <= x + 15 && y <= sy + 15 && sy <= y + 15)
        return 1;
    end
    return 0;
  endfunction

  task automatic do_scan(input string tag, input logic [N*ES-1:0] data, input bit bv,
                         input int bx, input int by, input bit quiet);
    int k, del_cyc, cons_cyc, done_cyc, n_del, addr, exp_del, exp_done, exp_ship, ship_seen;
    logic [N*ES-1:0] bait;
    k = model_hit(data, bv, bx, by);
    exp_ship = 0;
`ifdef SHIP_COLLISION_EN
    exp_ship = model_ship(data, int'(ship_x), int'(ship_y));
    exp_del  = (k >= 0) ? N + 1 : -1;
    exp_done = (k >= 0) ? N + 2 : N + 1;
`else
    exp_del  = (k >= 0) ? k + 2 : -1;
    exp_done = (k >= 0) ? k + 3 : N + 1;
`endif
    if (k >= 0) exp_score = (exp_score + 10 > 65535) ? 65535 : exp_score + 10;
    for (int i = 0; i < N; i++) bait[i*ES +: ES] = ent(1'b1, bx, by);
    del_cyc = -1; cons_cyc = -1; done_cyc = -1; n_del = 0; addr = -1; ship_seen = 0;
    @(negedge clk);
    asteroids_data = data;
    bullet_valid = bv;
    bullet_x = 10'(bx);
    bullet_y = 10'(by);
    start = 1'b1;
    for (int cyc = 1; cyc <= 12 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        asteroids_data = bait;
        bullet_valid = 1'b1;
        if (!quiet) check({tag, ".busy"}, int'(busy), 1);
      end
      if (cyc == 2) start = 1'b1;
      if (cyc == 3) start = 1'b0;
      if (delete_asteroid) begin
        n_del++;
        if (del_cyc < 0) begin
          del_cyc = cyc;
          addr = int'(asteroid_address);
        end
      end
      if (bullet_consume && cons_cyc < 0) cons_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
`ifdef SHIP_COLLISION_EN
        ship_seen = int'(ship_hit);
`endif
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (!quiet) begin
      check({tag, ".del_cyc"}, del_cyc, exp_del);
      check({tag, ".cons_cyc"}, cons_cyc, exp_del);
      check({tag, ".n_del"}, n_del, (k >= 0) ? 1 : 0);
      if (k >= 0) check({tag, ".addr"}, addr, k);
      check({tag, ".done_cyc"}, done_cyc, exp_done);
      check({tag, ".score"}, int'(score), exp_score);
      check({tag, ".idle"}, int'({busy, done, delete_asteroid}), 0);
      check({tag, ".ship"}, ship_seen, exp_ship);
    end
  endtask

  initial begin
    logic [N*ES-1:0] d;
    int bx, by, seen;
    reset_n = 1'b0;
    start = 1'b0;
    asteroids_data = '0;
    bullet_valid = 1'b0;
    bullet_x = '0;
    bullet_y = '0;
`ifdef SHIP_COLLISION_EN
    ship_x = 10'd900;
    ship_y = 10'd900;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset.outs",
            int'({busy, done, delete_asteroid, bullet_consume, asteroid_address}), 0);
      check("reset.score", int'(score), 0);
    end

    d = '0;
    d[2*ES +: ES] = ent(1'b1, 100, 50);
    do_scan("basic", d, 1'b1, 108, 60, 1'b0);

    // Reset mid-scan: entry 3 would hit, but the scan is aborted
    d = '0;
    d[3*ES +: ES] = ent(1'b1, 100, 50);
    @(negedge clk);
    asteroids_data = d; bullet_valid = 1'b1; bullet_x = 10'd105; bullet_y = 10'd55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid.busy", int'(busy), 0);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (delete_asteroid || done || busy) seen++;
    end
    check("rst_mid.quiet", seen, 0);
    exp_score = 0;
    check("rst_mid.score", int'(score), exp_score);

    d = '0;
    d[1*ES +: ES] = ent(1'b1, 100, 50);
    d[3*ES +: ES] = ent(1'b1, 95, 45);
    do_scan("two_hits", d, 1'b1, 105, 55, 1'b0);

    d = '0;
    d[0*ES +: ES] = ent(1'b1, 100, 50);
    do_scan("edge_in", d, 1'b1, 115, 65, 1'b0);
    do_scan("edge_out", d, 1'b1, 116, 60, 1'b0);
    do_scan("edge_outy", d, 1'b1, 110, 66, 1'b0);
    do_scan("edge_lo", d, 1'b1, 100, 50, 1'b0);
    do_scan("edge_below", d, 1'b1, 99, 50, 1'b0);

    d = '0;
    d[3*ES +: ES] = ent(1'b1, 1015, 1000);
    do_scan("no_wrap", d, 1'b1, 1023, 1010, 1'b0);

    d = '0;
    d[2*ES +: ES] = ent(1'b0, 100, 50);
    do_scan("invalid", d, 1'b1, 108, 60, 1'b0);
    d[2*ES +: ES] = ent(1'b1, 100, 50);
    do_scan("no_bullet", d, 1'b0, 108, 60, 1'b0);

`ifdef SHIP_COLLISION_EN
    ship_x = 10'd200;
    ship_y = 10'd200;
    d = '0;
    d[0*ES +: ES] = ent(1'b1, 210, 205);
    do_scan("ship", d, 1'b1, 212, 207, 1'b0);
    ship_x = 10'd900;
    ship_y = 10'd900;
`endif

    for (int t = 0; t < 40; t++) begin
      bx = int'($urandom_range(0, 1023));
      by = int'($urandom_range(0, 1023));
      for (int i = 0; i < N; i++)
        d[i*ES +: ES] = ent($urandom_range(0, 3) != 0,
                            (bx + 1024 - int'($urandom_range(0, 20))) % 1024,
                            (by + 1024 - int'($urandom_range(0, 20))) % 1024);
`ifdef SHIP_COLLISION_EN
      ship_x = 10'($urandom_range(0, 1023));
      ship_y = 10'($urandom_range(0, 1023));
`endif
      do_scan("rand", d, $urandom_range(0, 4) != 0, bx, by, 1'b0);
    end

    // Drive the score close to saturation, then cross it
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_score = 0;
    d = '0;
    d[0*ES +: ES] = ent(1'b1, 300, 300);
    for (int i = 0; i < 6553; i++) do_scan("pre", d, 1'b1, 305, 305, 1'b1);
    check("preload.score", int'(score), 65530);
    do_scan("sat", d, 1'b1, 305, 305, 1'b0);
    check("sat.score", int'(score), 65535);
    do_scan("sat2", d, 1'b1, 305, 305, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asteroid_hit_detector.md
Name: asteroid_hit_detector

Overview:
- Sits directly downstream of the asteroid controller. Consumes its packed asteroid entity array and the current bullet position.
- Once per frame tick, scans all entries for a bullet/asteroid overlap.
- On the first hit it drives the controller's delete_asteroid/asteroid_address inputs, consumes the bullet and bumps the score.

Parameters:
- ASTEROID_COUNT, 4, number of entity slots scanned.
- ENTITY_SIZE, 34, bits per entity.
- ADDR_W, 2, index width; must be at least clog2(ASTEROID_COUNT).
- ASTEROID_W, 16, asteroid bounding-box side in pixels.
- POINTS, 10, score increment per hit.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  frame tick; begins a scan when idle
- asteroids_data  in  ASTEROID_COUNT*ENTITY_SIZE  entity i at bits [i*ENTITY_SIZE +: ENTITY_SIZE]; per entity: [33] valid, [25:16] y, [15:6] x
- bullet_valid  in  1  bullet in flight
- bullet_x  in  10  bullet x pixel
- bullet_y  in  10  bullet y pixel
- busy  out  1  high while a scan is in progress (state not IDLE)
- done  out  1  one-cycle pulse at end of every scan
- delete_asteroid  out  1  one-cycle pulse, to controller
- asteroid_address  out  ADDR_W  index of asteroid to delete; valid while delete_asteroid is high
- bullet_consume  out  1  one-cycle pulse, coincident with delete_asteroid
- score  out  16  accumulated score

Behaviour:
- Reset is clk, reset_n: synchronous, active-low.
- Reset values: state IDLE, busy=0, done=0, delete_asteroid=0, bullet_consume=0, asteroid_address=0, score=0, index=0.
- Reset mid-scan aborts the scan; no delete or done pulse is issued.
- FSM states: IDLE, SCAN, HIT, DONE.
- IDLE: when start=1, snapshot asteroids_data, bullet_valid, bullet_x and bullet_y into internal registers; clear index; go to SCAN.
  - All comparisons use the snapshot, so asteroid motion during the scan is ignored.
- SCAN: evaluate one entry per cycle, entry[index] of the snapshot.
- Hit condition: valid=1, latched bullet_valid=1, x <= bx <= x+ASTEROID_W-1, and y <= by <= y+ASTEROID_W-1.
  - Sums are computed at 11 bits; there is no screen wrap.
  - An asteroid at x=1015 covers x 1015..1030, so bullet x 1023 hits it.
- On a hit: latch index into the hit register; go to HIT.
- No hit and index==ASTEROID_COUNT-1: go to DONE. Otherwise index increments.
- HIT (one cycle): delete_asteroid=1, bullet_consume=1, asteroid_address=hit index.
  - score <= score+POINTS, saturating at 16'hFFFF.
  - Then go to DONE.
- DONE (one cycle): done=1; go to IDLE.
- Latency, with start sampled in cycle 0:
  - Entry k is evaluated in cycle 1+k.
  - Hit on entry k: delete in cycle k+2, done in cycle k+3.
  - No hit: done in cycle ASTEROID_COUNT+1.
- At most one hit per scan; the lowest index wins.
- start while busy is ignored; it is not queued.
- Latched bullet_valid=0 forces a full scan with no hit, then done.
- All outputs are registered.

Optional Feature:
- Macro: SHIP_COLLISION_EN.
- When defined, adds inputs ship_x[9:0] and ship_y[9:0] and output ship_hit (1 bit, reset 0). These are snapshotted at start alongside the bullet.
- Each scanned entry is also box-tested against the ship's box, SHIP_W=16 (a localparam); same inclusive-overlap rule, with box [sx..sx+15] x [sy..sy+15].
- The scan always runs all ASTEROID_COUNT entries.
- A bullet hit records only the first (lowest-index) hit; HIT is entered after the last entry.
  - Delete for a hit then occurs in cycle ASTEROID_COUNT+1; done follows in ASTEROID_COUNT+2.
- ship_hit pulses together with done if any valid entry overlapped the ship.
- When undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset, then 5 idle cycles: all outputs 0, score=0. Asserting reset at cycle 2 of a scan: no delete, no done, busy=0 next cycle.
- Entry 2 valid at x=100, y=50; bullet (108,60) valid; start: delete_asteroid and bullet_consume in cycle 4, asteroid_address=2, score=10, done in cycle 5.
- Entries 1 and 3 both overlap the bullet: only index 1 is deleted, in cycle 3; exactly one delete per scan.
- Boundary: asteroid at x=100, y=50 with bullet x=115 → hit; bullet x=116 → no hit, done in cycle 5.
- Invalid entry overlapping the bullet, or bullet_valid=0: no delete, done in cycle 5, score unchanged. start pulsed during the scan: ignored.
- Preload score near max via 6553 hits, then one more hit: score saturates at 16'hFFFF. With SHIP_COLLISION_EN: ship (200,200), asteroid at (210,205) → ship_hit=1 with done in cycle 6.
